// File: rtl/ps2_scancode_fifo.sv
// ps2_scancode_fifo: assembles PS/2 Set-2 bytes into key events and buffers them for the CPU
module ps2_scancode_fifo #(
   parameter int DEPTH = 16,
   parameter int TIMEOUT = 1000000,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_done_tick,
   input  logic [7:0]        rx_data,
   input  logic              rd_en,
   output logic [9:0]        rd_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              clr_overflow,
   output logic              irq
);
   localparam int TW = $clog2(TIMEOUT) + 1;
   typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;
   state_t state, nxt;
   logic [2:0] skip, skip_nxt;
   logic [TW-1:0] idle_cnt;
   logic [9:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic push, pop, wr, drop, filt, ext_s, brk_s;
   logic [9:0] ev;
   assign ext_s = (state == EXT) || (state == EXT_BRK);
   assign brk_s = (state == BRK) || (state == EXT_BRK);
   assign filt = (rx_data == 8'h00) || (rx_data == 8'hAA) || (rx_data == 8'hEE) ||
                 (rx_data == 8'hFA) || (rx_data == 8'hFE) || (rx_data == 8'hFF);
   // decode the incoming byte against the prefix state; push lands on the same edge as the byte
   always_comb begin
      push = 1'b0;
      ev = 10'h000;
      nxt = state;
      skip_nxt = skip;
      if (rx_done_tick) begin
         if (state == PAUSE) begin
            skip_nxt = skip - 3'd1;
            if (skip == 3'd1) begin
               push = 1'b1;
               ev = 10'h177;
               nxt = IDLE;
            end
         end else if (rx_data == 8'hE0) begin
            nxt = EXT;
         end else if (rx_data == 8'hF0) begin
            nxt = ext_s ? EXT_BRK : BRK;
         end else if (rx_data == 8'hE1) begin
            nxt = PAUSE;
            skip_nxt = 3'd7;
         end else if (filt) begin
            nxt = IDLE;
         end else begin
            push = 1'b1;
            ev = {brk_s, ext_s, rx_data};
            nxt = IDLE;
         end
      end else if (state != IDLE && idle_cnt == TW'(TIMEOUT - 1)) begin
         nxt = IDLE;
      end
   end
   // decoder state, pause skip counter and prefix timeout counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         skip <= 3'd0;
         idle_cnt <= '0;
      end else begin
         state <= nxt;
         skip <= skip_nxt;
         idle_cnt <= (rx_done_tick || nxt == IDLE) ? '0 : idle_cnt + 1'b1;
      end
   end
   assign empty = (count == '0);
   assign full = (count == (ADDR_W + 1)'(DEPTH));
   assign pop = rd_en && !empty;
   assign wr = push && (!full || pop);
   assign drop = push && full && !pop;
   assign rd_data = empty ? 10'h000 : mem[rd_ptr];
   // event storage, written only when there is room (or room is being made this cycle)
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= ev;
   end
   // pointers, occupancy, sticky overflow and the per-event interrupt pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
         irq <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (ADDR_W + 1)'(wr) - (ADDR_W + 1)'(pop);
         overflow <= drop || (overflow && !clr_overflow);
         irq <= wr;
      end
   end
endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// tb_ps2_scancode_fifo: directed and random checks of ps2_scancode_fifo against a queue-based model
module tb_ps2_scancode_fifo;
   localparam int DEPTH = 8;
   localparam int TIMEOUT = 16;
   localparam int AW = $clog2(DEPTH);
   logic clk = 1'b0, reset = 1'b1, rx_done_tick = 1'b0, rd_en = 1'b0, clr_overflow = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [9:0] rd_data;
   logic empty, full, overflow, irq;
   logic [AW:0] count;
   int n_cmp = 0, n_bad = 0;
   logic [9:0] q[$];
   logic m_ext, m_brk, m_ovf, m_irq;
   int m_pause, m_gap;
   logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hAA, 8'hFA, 8'hFF, 8'h1C, 8'h75, 8'h77, 8'h14, 8'h5A};

   ps2_scancode_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data), .rd_en(rd_en),
      .rd_data(rd_data), .empty(empty), .full(full), .count(count), .overflow(overflow),
      .clr_overflow(clr_overflow), .irq(irq));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_prefix();
      m_ext = 1'b0;
      m_brk = 1'b0;
      m_pause = 0;
      m_gap = 0;
   endtask

   task automatic model_edge(input logic rx, input logic [7:0] d, input logic rd, input logic clr);
      logic p, popq;
      logic [9:0] e;
      int sz;
      p = 1'b0;
      e = 10'h000;
      if (rx) begin
         m_gap = 0;
         if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) begin
               p = 1'b1;
               e = 10'h177;
            end
         end else if (d == 8'hE0) begin
            m_ext = 1'b1;
            m_brk = 1'b0;
         end else if (d == 8'hF0) begin
            m_brk = 1'b1;
         end else if (d == 8'hE1) begin
            clear_prefix();
            m_pause = 7;
         end else if (d inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
            clear_prefix();
         end else begin
            p = 1'b1;
            e = {m_brk, m_ext, d};
            clear_prefix();
         end
      end else if (m_ext || m_brk || m_pause > 0) begin
         m_gap++;
         if (m_gap >= TIMEOUT) clear_prefix();
      end
      sz = q.size();
      popq = rd && sz > 0;
      if (popq) void'(q.pop_front());
      m_irq = 1'b0;
      if (p && (sz < DEPTH || popq)) begin
         q.push_back(e);
         m_irq = 1'b1;
      end
      m_ovf = (p && sz == DEPTH && !popq) ? 1'b1 : (clr ? 1'b0 : m_ovf);
   endtask

   task automatic check_outputs();
      chk("rd_data", 32'(rd_data), q.size() > 0 ? 32'(q[0]) : 32'h0);
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("irq", 32'(irq), 32'(m_irq));
   endtask

   task automatic step(input logic rx, input logic [7:0] d, input logic rd, input logic clr);
      rx_done_tick = rx;
      rx_data = d;
      rd_en = rd;
      clr_overflow = clr;
      @(posedge clk);
      model_edge(rx, d, rd, clr);
      #1;
      rx_done_tick = 1'b0;
      rd_en = 1'b0;
      clr_overflow = 1'b0;
      check_outputs();
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic pop_expect(input logic [9:0] e);
      chk("pop_head", 32'(rd_data), 32'(e));
      step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      q.delete();
      clear_prefix();
      m_ovf = 1'b0;
      m_irq = 1'b0;
      #1;
      reset = 1'b0;
      check_outputs();
   endtask

   initial begin
      logic [7:0] b;
      do_reset();
      send(8'h1C);
      chk("t1_irq", 32'(irq), 32'h1);
      chk("t1_data", 32'(rd_data), 32'h01C);
      chk("t1_count", 32'(count), 32'h1);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t1_irq_drop", 32'(irq), 32'h0);
      pop_expect(10'h01C);
      send(8'hF0); send(8'h1C); send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      pop_expect(10'h21C); pop_expect(10'h175); pop_expect(10'h375);
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      chk("t3_one_event", 32'(count), 32'h1);
      send(8'h1C);
      pop_expect(10'h177); pop_expect(10'h01C);
      for (int i = 0; i <= DEPTH; i++) send(8'h10 + 8'(i));
      chk("t4_full", 32'(full), 32'h1);
      chk("t4_count", 32'(count), 32'(DEPTH));
      chk("t4_ovf", 32'(overflow), 32'h1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t4_ovf_clr", 32'(overflow), 32'h0);
      for (int i = 0; i < DEPTH; i++) pop_expect(10'h010 + 10'(i));
      chk("t4_empty", 32'(empty), 32'h1);
      send(8'hE0);
      for (int i = 0; i < TIMEOUT; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
      send(8'h1C);
      pop_expect(10'h01C);
      send(8'hAA); send(8'hFA);
      chk("t5_filter", 32'(count), 32'h0);
      for (int i = 0; i < DEPTH; i++) send(8'h40 + 8'(i));
      step(1'b1, 8'h33, 1'b1, 1'b0);
      chk("t6_count", 32'(count), 32'(DEPTH));
      chk("t6_irq", 32'(irq), 32'h1);
      chk("t6_head", 32'(rd_data), 32'h041);
      for (int i = 1; i < DEPTH; i++) pop_expect(10'h040 + 10'(i));
      pop_expect(10'h033);
      send(8'hF0);
      do_reset();
      send(8'h1C);
      pop_expect(10'h01C);
      for (int i = 0; i < 3000; i++) begin
         b = $urandom_range(0, 12) == 12 ? 8'($urandom) : pool[$urandom_range(0, 11)];
         if ($urandom_range(0, 40) == 0)
            for (int k = 0; k < TIMEOUT + 3; k++) step(1'b0, 8'h00, $urandom_range(0, 3) == 0, 1'b0);
         step($urandom_range(0, 1) == 1, b, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
